// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel integer clock divider.
package clk_div_pkg;

    typedef enum logic {
        BYPASS = 1'b0,
        DIVIDE = 1'b1
    } state_e;

    localparam int MIN_DIV_RATIO = 2;

    // High-phase length of a divided period; the caller sizes the result to RATIO_W+1 bits.
    function automatic logic [31:0] high_len(input logic [31:0] r);
        return (r + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control and output bundle of the multi-channel clock divider.
interface clk_div_multi_if #(
    parameter int NUM_CH  = 4,
    parameter int RATIO_W = 8
);
    logic [NUM_CH-1:0]         i_clk_en;
    logic [NUM_CH*RATIO_W-1:0] i_div_ratio;
    logic [NUM_CH-1:0]         o_div_clk;
    logic [NUM_CH-1:0]         o_div_tick;
    logic [NUM_CH-1:0]         o_divide_active;

    modport master (
        output i_clk_en, i_div_ratio,
        input  o_div_clk, o_div_tick, o_divide_active
    );

    modport slave (
        input  i_clk_en, i_div_ratio,
        output o_div_clk, o_div_tick, o_divide_active
    );
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: BYPASS/DIVIDE FSM, period counter, registered clock and tick.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int RATIO_W = 8
) (
    input  logic               i_ref_clk,
    input  logic               i_rst_n,
    input  logic               i_clk_en,
    input  logic [RATIO_W-1:0] i_div_ratio,
    output logic               o_div_clk,
    output logic               o_div_tick,
    output logic               o_divide_active
);

    state_e             state_q, state_d;
    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic [RATIO_W-1:0] ratio_q, ratio_d;
    logic               clk_q, clk_d;
    logic               tick_q, tick_d;
    logic               req;
    logic               boundary;
    logic [RATIO_W:0]   high_d;

    assign req      = i_clk_en && (i_div_ratio >= RATIO_W'(MIN_DIV_RATIO));
    assign boundary = (cnt_q == ratio_q - RATIO_W'(1));

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= BYPASS;
            cnt_q   <= '0;
            ratio_q <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    // Ratio and enable are sampled only on entry and at the period boundary.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        unique case (state_q)
            BYPASS: begin
                if (req) begin
                    state_d = DIVIDE;
                    ratio_d = i_div_ratio;
                    cnt_d   = '0;
                end
            end
            DIVIDE: begin
                if (!boundary) begin
                    cnt_d = cnt_q + RATIO_W'(1);
                end else if (req) begin
                    ratio_d = i_div_ratio;
                    cnt_d   = '0;
                end else begin
                    state_d = BYPASS;
                    cnt_d   = '0;
                end
            end
            default: state_d = BYPASS;
        endcase

        high_d = (RATIO_W+1)'(high_len(32'(ratio_d)));
        clk_d  = (state_d == DIVIDE) && ({1'b0, cnt_d} < high_d);
        tick_d = (state_d == BYPASS) || (cnt_d == '0);
    end

    // The select is the registered state bit, so the switch happens only on a boundary edge.
    assign o_div_clk       = (state_q == DIVIDE) ? clk_q : i_ref_clk;
    assign o_div_tick      = tick_q;
    assign o_divide_active = (state_q == DIVIDE);

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent integer clock dividers sharing one reference clock.
module clk_div_multi #(
    parameter int NUM_CH  = 4,
    parameter int RATIO_W = 8
) (
    input  logic            i_ref_clk,
    input  logic            i_rst_n,
    clk_div_multi_if.slave  bus
);

    logic [NUM_CH-1:0] div_clk;
    logic [NUM_CH-1:0] div_tick;
    logic [NUM_CH-1:0] divide_active;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_div_ch #(
            .RATIO_W(RATIO_W)
        ) u_ch (
            .i_ref_clk      (i_ref_clk),
            .i_rst_n        (i_rst_n),
            .i_clk_en       (bus.i_clk_en[k]),
            .i_div_ratio    (bus.i_div_ratio[k*RATIO_W +: RATIO_W]),
            .o_div_clk      (div_clk[k]),
            .o_div_tick     (div_tick[k]),
            .o_divide_active(divide_active[k])
        );
    end

    assign bus.o_div_clk       = div_clk;
    assign bus.o_div_tick      = div_tick;
    assign bus.o_divide_active = divide_active;

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel, parametrised integer clock divider: the next generation of the single-channel `clk_div`. It generates `NUM_CH` independent divided clocks from one reference clock. Each channel has its own enable and run-time ratio, and ratio/enable changes are applied only at period boundaries, so no runt pulses appear. A per-channel registered tick marks each divided-clock rising phase. It sits in the clock/reset subsystem and feeds peripheral clocks (UART, baud, etc.) and their clock-enable paths.

## Interface
- `NUM_CH`, default 4: number of independent channels.
- `RATIO_W`, default 8: ratio and counter width; maximum ratio is 2^RATIO_W−1.
- `i_ref_clk`  in  1  reference clock; the only clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_clk_en`  in  NUM_CH  per-channel divide enable.
- `i_div_ratio`  in  NUM_CH*RATIO_W  flattened ratios; channel k occupies bits [k*RATIO_W +: RATIO_W].
- `o_div_clk`  out  NUM_CH  divided clock, or `i_ref_clk` in bypass.
- `o_div_tick`  out  NUM_CH  registered one-ref-cycle pulse at the start of each divided period.
- `o_divide_active`  out  NUM_CH  1 when the channel is in DIVIDE.

## Operation
- Each channel runs an FSM with two states: BYPASS and DIVIDE.
- **Request.** A request is valid when `i_clk_en[k]`=1 and the ratio for channel k is ≥ 2.
- **BYPASS.**
  - `o_div_clk[k]` = `i_ref_clk`.
  - `o_div_tick[k]`=1.
  - `o_divide_active[k]`=0.
  - On any posedge with a valid request: latch R ← ratio, cnt ← 0, clk_reg ← 1, go to DIVIDE.
- **DIVIDE.**
  - cnt counts 0..R−1 and wraps to 0.
  - H = (R+1)>>1. clk_reg is 1 for cnt in [0, H−1] and 0 for cnt in [H, R−1].
  - Result: even R gives 50% duty; odd R gives H high cycles and H−1 low cycles.
- **Period boundary.** The boundary is the posedge leaving cnt = R−1.
  - Valid request at the boundary: R ← current ratio (which may differ from the old R), cnt ← 0, clk_reg ← 1.
  - No valid request at the boundary (enable low, or ratio 0/1): go to BYPASS.
- **Mid-period changes.** Ratio or enable changes inside a period are ignored until that period's boundary completes.
- **Output select.** The bypass/divide select is a registered bit updated only at the boundary edge, so the output stays high across the switch.
- **Tick.** `o_div_tick[k]` is registered. In DIVIDE it is 1 exactly in the ref cycle where cnt = 0.
- **Arithmetic.** Unsigned throughout. The H computation is RATIO_W+1 bits wide so that R = 2^RATIO_W−1 cannot overflow.
- **Channels** are fully independent; no shared state.

## Timing
- **Reset (asynchronous, any time, including mid-period)** sets, for all channels:
  - state = BYPASS, cnt = 0, R = 0, clk_reg = 0, select = bypass.
  - Therefore `o_div_clk` = `i_ref_clk`, `o_div_tick` = 1, `o_divide_active` = 0.
- **Reset release.** The first posedge after release with a valid request enters DIVIDE. `o_div_clk` rises on that edge.
- **Period latency.** A newly applied ratio shows on the first edge after the current period ends. Worst-case latency is R_old ref cycles.
- **Simultaneous events.** A ratio change and a disable in the same boundary cycle: disable wins (go to BYPASS).
- **R=2 boundary.** H=1, so the output toggles every ref cycle and the tick fires every 2 cycles.
- **Wrap-around.** cnt never exceeds R−1. The latched R is held constant for a full period.

## Structure
- **Package `clk_div_pkg`:**
  - state enum {BYPASS, DIVIDE}.
  - constant MIN_DIV_RATIO = 2.
  - function `high_len(R)` returning (R+1)>>1.
- **Sub-module `clk_div_ch`:** one channel, with parameter `RATIO_W`.
- **Top `clk_div_multi`:** a generate loop instantiates `NUM_CH` copies and slices the flattened ratio bus.

## Test plan
- **Reset:** assert `i_rst_n`=0 mid-DIVIDE (R=6, cnt=3) → all outputs immediately show bypass/tick=1/active=0. After release with en=1, ratio=6 → first edge shows clk high, then 3 high / 3 low cycles.
- **Even and odd ratios:** ratio=4 → 2 high / 2 low, tick every 4 cycles. Ratio=5 → 3 high / 2 low. Ratio=255 (RATIO_W=8) → 128 high / 127 low.
- **Ratio change mid-period:** R=4, switch input to 6 at cnt=1 → remaining 2 cycles of the R=4 period complete, then a 3 high / 3 low period begins. No shortened pulse.
- **Disable and bypass:** en dropped at cnt=2 of R=8 → divided clock completes 4 high / 4 low, then bypass with tick=1. Ratio 0 or 1 with en=1 → bypass.
- **Simultaneous boundary events:** ratio change and en=0 in the same boundary cycle → BYPASS.
- **Channel independence:** ch0 ratio=3, ch1 ratio=7, ch2 disabled, ch3 ratio=2, all running concurrently → each waveform and tick stream matches its own reference model. Changes on one channel never perturb another.
